interrupt_aggregator: RTL and testbench

INTERRUPT_AGGREGATOR -- requirements
Module: interrupt_aggregator

---
 rtl/fpgc_irq_pkg.sv | 14 +
 rtl/irq_sync_ch.sv | 36 +++
 rtl/interrupt_aggregator.sv | 98 +++++++++
 tb/tb_interrupt_aggregator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fpgc_irq_pkg.sv
// Shared definitions for the interrupt aggregator: config register selects
// and the width helper for the priority-encoded channel id.
package fpgc_irq_pkg;

  localparam logic [1:0] SEL_MASK = 2'd0;
  localparam logic [1:0] SEL_POL  = 2'd1;
  localparam logic [1:0] SEL_MODE = 2'd2;
  localparam logic [1:0] SEL_PEND = 2'd3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sync_ch.sv
// One interrupt channel front end: synchronizer chain, delayed copy,
// polarity correction and edge-event detection.
module irq_sync_ch #(
  parameter int   SYNC_STAGES = 3,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic pol,
  input  logic suppress,
  output logic lvl,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;

  // Reset loads the deasserted level so a source already active at
  // release is seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      p_q    <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
      p_q    <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both samples are corrected with the current polarity, so a polarity
  // write alone never looks like a transition.
  assign lvl = sync_q[SYNC_STAGES-1] ^ pol;
  assign evt = lvl & ~(p_q ^ pol) & ~suppress;

endmodule

// File: rtl/interrupt_aggregator.sv
// Interrupt aggregator: per-channel sync/edge front ends, pending latch with
// W1C, mask, rising pulse per channel, registered readback and priority id.
module interrupt_aggregator
  import fpgc_irq_pkg::*;
#(
  parameter int             NCH         = 8,
  parameter int             SYNC_STAGES = 3,
  parameter logic [NCH-1:0] MASK_RESET  = '1,
  parameter logic [NCH-1:0] POL_RESET   = '0,
  parameter logic [NCH-1:0] EDGE_RESET  = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          irq_in,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [NCH-1:0]          cfg_d,
  output logic [NCH-1:0]          cfg_q,
  output logic [NCH-1:0]          pending,
  output logic [NCH-1:0]          int_pulse,
  output logic                    irq_out,
  output logic [id_w(NCH)-1:0]    irq_id
);

  localparam int IDW = id_w(NCH);

  logic [NCH-1:0] mask_q, pol_q, mode_q, pend_q, pm_q, sup_q;
  logic [NCH-1:0] lvl, evt, w1c, sup_d, pend_d, act;
  logic           wr_mask, wr_pol, wr_mode, wr_pend;

  assign wr_mask = cfg_we && (cfg_sel == SEL_MASK);
  assign wr_pol  = cfg_we && (cfg_sel == SEL_POL);
  assign wr_mode = cfg_we && (cfg_sel == SEL_MODE);
  assign wr_pend = cfg_we && (cfg_sel == SEL_PEND);

  assign w1c   = wr_pend ? cfg_d : '0;
  assign sup_d = (wr_pol  ? (cfg_d ^ pol_q)  : '0) |
                 (wr_mode ? (cfg_d ^ mode_q) : '0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    irq_sync_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (POL_RESET[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .irq      (irq_in[i]),
      .pol      (pol_q[i]),
      .suppress (sup_q[i]),
      .lvl      (lvl[i]),
      .evt      (evt[i])
    );
  end

  // Edge channels: set beats clear. Level channels follow the level.
  always_comb begin
    pend_d = (mode_q & ((pend_q & ~w1c) | evt)) | (~mode_q & lvl);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= MASK_RESET;
      pol_q     <= POL_RESET;
      mode_q    <= EDGE_RESET;
      pend_q    <= '0;
      pm_q      <= '0;
      sup_q     <= '0;
      int_pulse <= '0;
      cfg_q     <= '0;
    end else begin
      if (wr_mask) mask_q <= cfg_d;
      if (wr_pol)  pol_q  <= cfg_d;
      if (wr_mode) mode_q <= cfg_d;
      pend_q    <= pend_d;
      sup_q     <= sup_d;
      pm_q      <= act;
      int_pulse <= act & ~pm_q;
      case (cfg_sel)
        SEL_MASK: cfg_q <= mask_q;
        SEL_POL:  cfg_q <= pol_q;
        SEL_MODE: cfg_q <= mode_q;
        default:  cfg_q <= pend_q;
      endcase
    end
  end

  assign pending = pend_q;
  assign act     = pend_q & mask_q;
  assign irq_out = |act;

  always_comb begin
    irq_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (act[i]) irq_id = IDW'(i);
    end
  end

endmodule

// File: tb/tb_interrupt_aggregator.sv
// Scenario bench for interrupt_aggregator (NCH=8, SYNC_STAGES=3, defaults);
// int_pulse activity is scoreboarded against expected pulse vectors.
module tb_interrupt_aggregator;
  import fpgc_irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_in = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [7:0] cfg_d = '0;
  logic [7:0] cfg_q, pending, int_pulse;
  logic       irq_out;
  logic [2:0] irq_id;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  interrupt_aggregator #(.NCH(8), .SYNC_STAGES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_d     (cfg_d),
    .cfg_q     (cfg_q),
    .pending   (pending),
    .int_pulse (int_pulse),
    .irq_out   (irq_out),
    .irq_id    (irq_id)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && int_pulse !== 8'h00) obs_q.push_back(int_pulse);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_d = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    step(2);
    n_chk++; if (pending !== 8'h00) $display("FAIL rst_pend got %h exp 00", pending); else n_pass++;
    n_chk++; if (int_pulse !== 8'h00) $display("FAIL rst_pulse got %h exp 00", int_pulse); else n_pass++;
    n_chk++; if (cfg_q !== 8'h00) $display("FAIL rst_cfgq got %h exp 00", cfg_q); else n_pass++;
    n_chk++; if (irq_out !== 1'b0 || irq_id !== 3'd0) $display("FAIL rst_irq got %b/%0d exp 0/0", irq_out, irq_id); else n_pass++;
    reset = 1'b0;
    cfg_sel = SEL_MASK; step();
    n_chk++; if (cfg_q !== 8'hFF) $display("FAIL rst_mask got %h exp ff", cfg_q); else n_pass++;
    cfg_sel = SEL_POL; step();
    n_chk++; if (cfg_q !== 8'h00) $display("FAIL rst_pol got %h exp 00", cfg_q); else n_pass++;
    cfg_sel = SEL_MODE; step();
    n_chk++; if (cfg_q !== 8'hFF) $display("FAIL rst_mode got %h exp ff", cfg_q); else n_pass++;
  endtask

  task automatic test_edge_latency;
    logic [7:0] o, e;
    irq_in[2] = 1'b1; exp_q.push_back(8'h04);
    step(3);
    n_chk++; if (pending !== 8'h00) $display("FAIL lat_early got %h exp 00", pending); else n_pass++;
    step();
    n_chk++; if (pending !== 8'h04) $display("FAIL lat_pend got %h exp 04", pending); else n_pass++;
    n_chk++; if (irq_out !== 1'b1 || irq_id !== 3'd2) $display("FAIL lat_id got %b/%0d exp 1/2", irq_out, irq_id); else n_pass++;
    step();
    n_chk++; if (int_pulse !== 8'h04) $display("FAIL lat_pulse_hi got %h exp 04", int_pulse); else n_pass++;
    step();
    n_chk++; if (int_pulse !== 8'h00) $display("FAIL lat_pulse_lo got %h exp 00", int_pulse); else n_pass++;
    cfg_sel = SEL_PEND; step();
    n_chk++; if (cfg_q !== 8'h04) $display("FAIL rd_pend got %h exp 04", cfg_q); else n_pass++;
    step();
    n_chk++; if (pending !== 8'h04 || cfg_q !== 8'h04) $display("FAIL rd_nondestr got %h/%h exp 04/04", pending, cfg_q); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL lat_sb_cnt got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL lat_sb got %h exp %h", o, e); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_w1c;
    logic [7:0] o, e;
    irq_in[5] = 1'b1; exp_q.push_back(8'h20);
    step(5);
    n_chk++; if (pending !== 8'h24 || irq_id !== 3'd2) $display("FAIL w1c_pre got %h/%0d exp 24/2", pending, irq_id); else n_pass++;
    cfg_write(SEL_PEND, 8'h04);
    n_chk++; if (pending !== 8'h20 || irq_id !== 3'd5) $display("FAIL w1c_clr got %h/%0d exp 20/5", pending, irq_id); else n_pass++;
    irq_in[5] = 1'b0; step(5);
    irq_in[5] = 1'b1; step(3);
    cfg_write(SEL_PEND, 8'h20);
    n_chk++; if (pending !== 8'h20) $display("FAIL w1c_setwins got %h exp 20", pending); else n_pass++;
    step(2);
    cfg_write(SEL_PEND, 8'h20);
    n_chk++; if (pending !== 8'h00 || irq_out !== 1'b0 || irq_id !== 3'd0) $display("FAIL w1c_all got %h/%b/%0d exp 00/0/0", pending, irq_out, irq_id); else n_pass++;
    irq_in = 8'h00; step(5);
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL w1c_sb_cnt got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL w1c_sb got %h exp %h", o, e); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mask;
    logic [7:0] o, e;
    cfg_write(SEL_MASK, 8'hFB);
    irq_in[2] = 1'b1; step(2);
    irq_in[2] = 1'b0; step(5);
    n_chk++; if (pending !== 8'h04) $display("FAIL msk_pend got %h exp 04", pending); else n_pass++;
    n_chk++; if (irq_out !== 1'b0 || irq_id !== 3'd0) $display("FAIL msk_irq got %b/%0d exp 0/0", irq_out, irq_id); else n_pass++;
    n_chk++; if (obs_q.size() != 0) $display("FAIL msk_nopulse got %0d exp 0", obs_q.size()); else n_pass++;
    obs_q.delete();
    exp_q.push_back(8'h04);
    cfg_write(SEL_MASK, 8'hFF);
    step(3);
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL msk_sb_cnt got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL msk_sb got %h exp %h", o, e); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
    cfg_write(SEL_PEND, 8'h04); step();
    n_chk++; if (pending !== 8'h00) $display("FAIL msk_clr got %h exp 00", pending); else n_pass++;
  endtask

  task automatic test_level;
    logic [7:0] o, e;
    cfg_write(SEL_MASK, 8'hFE);
    cfg_write(SEL_MODE, 8'hFE);
    irq_in[0] = 1'b1; step(5);
    cfg_write(SEL_POL, 8'h01); step(3);
    n_chk++; if (pending !== 8'h00) $display("FAIL lvl_idle got %h exp 00", pending); else n_pass++;
    cfg_write(SEL_MASK, 8'hFF); step(2);
    obs_q.delete();
    exp_q.push_back(8'h01);
    irq_in[0] = 1'b0; step(3);
    n_chk++; if (pending !== 8'h00) $display("FAIL lvl_early got %h exp 00", pending); else n_pass++;
    step();
    n_chk++; if (pending !== 8'h01) $display("FAIL lvl_set got %h exp 01", pending); else n_pass++;
    cfg_write(SEL_PEND, 8'h01); step(2);
    n_chk++; if (pending !== 8'h01) $display("FAIL lvl_w1c got %h exp 01", pending); else n_pass++;
    irq_in[0] = 1'b1; step(3);
    n_chk++; if (pending !== 8'h01) $display("FAIL lvl_hold got %h exp 01", pending); else n_pass++;
    step();
    n_chk++; if (pending !== 8'h00) $display("FAIL lvl_drop got %h exp 00", pending); else n_pass++;
    cfg_write(SEL_MODE, 8'hFF);
    cfg_write(SEL_POL, 8'h00); step(4);
    n_chk++; if (pending !== 8'h00) $display("FAIL lvl_restore got %h exp 00", pending); else n_pass++;
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL lvl_sb_cnt got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL lvl_sb got %h exp %h", o, e); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pol_change;
    cfg_write(SEL_POL, 8'h01); step(4);
    n_chk++; if (pending !== 8'h00 || irq_out !== 1'b0) $display("FAIL pol_noevt got %h/%b exp 00/0", pending, irq_out); else n_pass++;
    cfg_write(SEL_POL, 8'h00); step(4);
    n_chk++; if (pending !== 8'h00) $display("FAIL pol_back got %h exp 00", pending); else n_pass++;
    n_chk++; if (obs_q.size() != 0) $display("FAIL pol_nopulse got %0d exp 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] o, e;
    irq_in = 8'h00; step(5);
    exp_q.push_back(8'hFF);
    irq_in = 8'hFF; step(5);
    n_chk++; if (pending !== 8'hFF || irq_id !== 3'd0 || irq_out !== 1'b1) $display("FAIL mid_pre got %h/%0d exp ff/0", pending, irq_id); else n_pass++;
    step(2);
    irq_in = 8'h80; reset = 1'b1; cfg_sel = SEL_PEND; step();
    n_chk++; if (pending !== 8'h00 || cfg_q !== 8'h00 || int_pulse !== 8'h00) $display("FAIL mid_rst got %h/%h/%h exp 00/00/00", pending, cfg_q, int_pulse); else n_pass++;
    reset = 1'b0; cfg_sel = SEL_MASK;
    exp_q.push_back(8'h80);
    step();
    n_chk++; if (cfg_q !== 8'hFF) $display("FAIL mid_mask got %h exp ff", cfg_q); else n_pass++;
    step(3);
    n_chk++; if (pending !== 8'h80 || irq_id !== 3'd7) $display("FAIL mid_rearm got %h/%0d exp 80/7", pending, irq_id); else n_pass++;
    step(2);
    n_chk++; if (obs_q.size() != exp_q.size()) $display("FAIL mid_sb_cnt got %0d exp %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_chk++;
      if (o !== e) $display("FAIL mid_sb got %h exp %h", o, e); else n_pass++;
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_w1c();
    test_mask();
    test_level();
    test_pol_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
